// File: rtl/conv1_aer_event_queue_pkg.sv
// Shared definitions for the conv1 AER input event queue: FSM encoding,
// event word field slices and the conv1 input image bounds.
package conv1_aer_event_queue_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'b001,
    S_WAIT_START = 3'b010,
    S_WAIT_DONE  = 3'b100
  } state_e;

  localparam int EV_W    = 16;
  localparam int ROW_MSB = 15;
  localparam int ROW_LSB = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  localparam int CONV1_IMG_H = 28;
  localparam int CONV1_IMG_W = 28;

  function automatic logic [7:0] ev_row(input logic [EV_W-1:0] ev);
    return ev[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [7:0] ev_col(input logic [EV_W-1:0] ev);
    return ev[COL_MSB:COL_LSB];
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Register-based DEPTH x DATA_W event FIFO with synchronous flush.
// Storage is not reset; only pointers and occupancy are.
module aer_event_fifo
  import conv1_aer_event_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = EV_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + AW'(1);
      if (do_pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  // A push coinciding with flush is discarded.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/conv1_aer_event_queue.sv
// Layer-1 AER input queue: buffers spike events and dispatches them one at a
// time to the address generator. CONV1_AER_RANGE_CHECK_EN adds an out-of-range filter.
module conv1_aer_event_queue
  import conv1_aer_event_queue_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 8,
  parameter int IMG_H         = CONV1_IMG_H,
  parameter int IMG_W         = CONV1_IMG_W
) (
  input  logic                   work_clk,
  input  logic                   rst,
  input  logic                   spike_in_valid,
  input  logic [EV_W-1:0]        spike_in_addr,
  output logic                   spike_in_ready,
  input  logic                   flush,
  output logic [EV_W-1:0]        AER_conv_layer1,
  output logic                   AER_input_flag,
  input  logic                   operating_flag,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   err_stuck
`ifdef CONV1_AER_RANGE_CHECK_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (START_TIMEOUT < 1) begin : g_bad_timeout
    $error("START_TIMEOUT must be at least 1");
  end
  if ((IMG_H < 1) || (IMG_H > 256) || (IMG_W < 1) || (IMG_W > 256)) begin : g_bad_bounds
    $error("IMG_H/IMG_W must fit the 8-bit event fields");
  end

  state_e          state_q;
  logic [EV_W-1:0] word_q;
  logic            flag_q;
  logic            err_q;
  logic [TW-1:0]   tmo_q;

  logic            fifo_full, fifo_empty, accept, push, pop;
  logic [EV_W-1:0] fifo_rdata;

  assign spike_in_ready = !fifo_full;
  assign accept         = spike_in_valid && spike_in_ready;

`ifdef CONV1_AER_RANGE_CHECK_EN
  logic        in_range;
  logic [15:0] drop_q;

  assign in_range = ({1'b0, ev_row(spike_in_addr)} < 9'(IMG_H)) &&
                    ({1'b0, ev_col(spike_in_addr)} < 9'(IMG_W));
  assign push       = accept && in_range;
  assign drop_count = drop_q;

  // Out-of-range events are still handshaken so the encoder never stalls on them.
  always_ff @(posedge work_clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else if (accept && !in_range && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
  end
`else
  assign push = accept;
`endif

  assign pop = (state_q == S_IDLE) && !fifo_empty && !operating_flag;

  aer_event_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (EV_W)
  ) u_fifo (
    .clk_i   (work_clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (spike_in_addr),
    .rdata_o (fifo_rdata),
    .count_o (queue_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The held word survives flush: the generator may still be reading it.
  always_ff @(posedge work_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      flag_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            word_q  <= fifo_rdata;
            flag_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (operating_flag) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!operating_flag) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign AER_conv_layer1 = word_q;
  assign AER_input_flag  = flag_q;
  assign err_stuck       = err_q;

endmodule

// File: tb/tb_conv1_aer_event_queue.sv
// Scoreboard bench for conv1_aer_event_queue: stimulus pushes expected
// dispatches into a queue, a monitor pops and compares on each flag pulse.
module tb_conv1_aer_event_queue;

  localparam int DEPTH = 16;
  localparam int QW    = $clog2(DEPTH) + 1;
  localparam int IMG_H = 28;
  localparam int IMG_W = 28;
`ifdef CONV1_AER_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spike_in_valid = 1'b0;
  logic [15:0]   spike_in_addr = 16'h0;
  logic          flush = 1'b0;
  logic          gen_op = 1'b0;
  logic          force_busy = 1'b0;
  logic          operating_flag;
  logic          spike_in_ready, AER_input_flag, err_stuck;
  logic [15:0]   AER_conv_layer1;
  logic [QW-1:0] queue_count;
`ifdef CONV1_AER_RANGE_CHECK_EN
  logic [15:0]   drop_count;
`endif

  assign operating_flag = gen_op | force_busy;

  always #5 clk = ~clk;

  conv1_aer_event_queue #(
    .DEPTH(DEPTH), .START_TIMEOUT(8), .IMG_H(IMG_H), .IMG_W(IMG_W)
  ) dut (
    .work_clk        (clk),
    .rst             (rst),
    .spike_in_valid  (spike_in_valid),
    .spike_in_addr   (spike_in_addr),
    .spike_in_ready  (spike_in_ready),
    .flush           (flush),
    .AER_conv_layer1 (AER_conv_layer1),
    .AER_input_flag  (AER_input_flag),
    .operating_flag  (operating_flag),
    .queue_count     (queue_count),
    .err_stuck       (err_stuck)
`ifdef CONV1_AER_RANGE_CHECK_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          flag_cnt = 0;
  int          drop_exp = 0;
  logic [15:0] exp_q[$];

  // Generator model: 0 fixed delay/hold, 1 never responds, 2 random delay/hold.
  int gen_mode = 0;
  int gen_delay = 2;
  int gen_hold = 26;
  int gd, gh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [15:0] a);
    return (int'(a[15:8]) < IMG_H) && (int'(a[7:0]) < IMG_W);
  endfunction

  function automatic logic [15:0] rand_ev_in();
    logic [15:0] a;
    a = {8'($urandom_range(0, IMG_H - 1)), 8'($urandom_range(0, IMG_W - 1))};
    return a;
  endfunction

  // One clock of stimulus, starting and ending on a falling edge.
  task automatic cycle(input bit v, input logic [15:0] a, input bit f, output bit acc);
    spike_in_valid = v;
    spike_in_addr  = a;
    flush          = f;
    #1;
    acc = v && spike_in_ready;
    @(posedge clk);
    if (acc && RC_EN && !in_range(a) && drop_exp < 16'hFFFF) drop_exp++;
    if (f) exp_q.delete();
    else if (acc && (in_range(a) || !RC_EN)) exp_q.push_back(a);
    @(negedge clk);
    spike_in_valid = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic push_ev(input logic [15:0] a);
    bit acc;
    cycle(1'b1, a, 1'b0, acc);
    check("push_accept", 32'(acc), 1);
  endtask

  task automatic wait_drain(input int limit);
    int i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("drain", exp_q.size(), 0);
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_op_high(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (operating_flag) begin
        seen = 1'b1;
        break;
      end
    end
    check("op_rise_wait", 32'(seen), 1);
  endtask

  // Address generator model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && AER_input_flag && gen_mode != 1) begin
        gd = (gen_mode == 2) ? int'($urandom_range(1, 4)) : gen_delay;
        gh = (gen_mode == 2) ? int'($urandom_range(1, 8)) : gen_hold;
        repeat (gd) @(negedge clk);
        gen_op = 1'b1;
        repeat (gh) @(negedge clk);
        gen_op = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  int          cyc = 0;
  int          reissue_at = -1;
  bit          issued = 1'b0, in_done = 1'b0, prev_flag = 1'b0;
  logic [15:0] last_word = 16'h0;
  logic [15:0] exp_word;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        last_word  = 16'h0;
        prev_flag  = 1'b0;
        issued     = 1'b0;
        in_done    = 1'b0;
        reissue_at = -1;
      end else begin
        if (cyc == reissue_at) check("reissue_latency", 32'(AER_input_flag), 1);
        if (AER_input_flag) begin
          check("pulse_width", 32'(prev_flag), 0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_flag: got dispatch of %h, expected none at %0t",
                     AER_conv_layer1, $time);
          end else begin
            exp_word = exp_q.pop_front();
            check("dispatch_word", 32'(AER_conv_layer1), 32'(exp_word));
          end
          last_word = AER_conv_layer1;
          flag_cnt++;
          issued  = 1'b1;
          in_done = 1'b0;
        end else begin
          check("word_hold", 32'(AER_conv_layer1), 32'(last_word));
          if (issued && operating_flag) begin
            issued  = 1'b0;
            in_done = 1'b1;
          end else if (in_done && !operating_flag) begin
            in_done = 1'b0;
            if (exp_q.size() > 0) reissue_at = cyc + 1;
          end
        end
        check("queue_count", 32'(queue_count), exp_q.size());
        check("ready", 32'(spike_in_ready), (exp_q.size() < DEPTH) ? 1 : 0);
`ifdef CONV1_AER_RANGE_CHECK_EN
        check("drop_count", 32'(drop_count), drop_exp);
`endif
        prev_flag = AER_input_flag;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          n_acc, f0;
    logic [15:0] ev, first_ev, ev_x, ev_y;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_flag", 32'(AER_input_flag), 0);
    check("rst_word", 32'(AER_conv_layer1), 0);
    check("rst_count", 32'(queue_count), 0);
    check("rst_ready", 32'(spike_in_ready), 1);
    check("rst_err", 32'(err_stuck), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single event into an empty queue
    gen_mode = 0; gen_delay = 2; gen_hold = 26;
    f0 = flag_cnt;
    cycle(1'b1, 16'h0305, 1'b0, acc);
    check("single_accept", 32'(acc), 1);
    check("no_bypass", 32'(AER_input_flag), 0);
    @(posedge clk);
    #1;
    check("empty_latency", 32'(AER_input_flag), 1);
    check("single_word", 32'(AER_conv_layer1), 32'h0305);
    @(negedge clk);
    repeat (40) @(negedge clk);
    check("single_one_pulse", flag_cnt - f0, 1);
    check("single_word_final", 32'(AER_conv_layer1), 32'h0305);

    // Burst against a busy generator
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, rand_ev_in(), 1'b0, acc);
      if (acc) n_acc++;
    end
    check("burst_accepts", n_acc, 16);
    check("burst_count", 32'(queue_count), 16);
    check("burst_ready", 32'(spike_in_ready), 0);
    gen_mode = 2;
    force_busy = 1'b0;
    wait_drain(2000);

    // Stuck generator
    gen_mode = 1;
    check("err_clear", 32'(err_stuck), 0);
    ev_x = rand_ev_in();
    ev_y = rand_ev_in();
    push_ev(ev_x);
    push_ev(ev_y);
    check("stuck_issue", 32'(AER_input_flag), 1);
    repeat (7) @(posedge clk);
    #1;
    check("stuck_err_early", 32'(err_stuck), 0);
    @(posedge clk);
    #1;
    check("stuck_err_set", 32'(err_stuck), 1);
    @(posedge clk);
    #1;
    check("stuck_next_issue", 32'(AER_input_flag), 1);
    check("stuck_next_word", 32'(AER_conv_layer1), 32'(ev_y));
    @(negedge clk);
    repeat (12) @(negedge clk);
    check("stuck_err_sticky", 32'(err_stuck), 1);

    // Flush while the generator is operating
    gen_mode = 0; gen_delay = 2; gen_hold = 10;
    first_ev = rand_ev_in();
    push_ev(first_ev);
    for (int i = 0; i < 4; i++) push_ev(rand_ev_in());
    wait_op_high(20);
    @(negedge clk);
    cycle(1'b1, 16'h0101, 1'b1, acc);
    check("flush_count", 32'(queue_count), 0);
    check("flush_word_held", 32'(AER_conv_layer1), 32'(first_ev));
    f0 = flag_cnt;
    repeat (30) @(negedge clk);
    check("flush_no_flags", flag_cnt - f0, 0);

    // Range boundary events
    gen_mode = 0; gen_delay = 2; gen_hold = 4;
    f0 = flag_cnt;
    push_ev(16'h1C00);
    push_ev(16'h0203);
`ifdef CONV1_AER_RANGE_CHECK_EN
    check("range_drop", 32'(drop_count), 1);
`endif
    wait_drain(200);
    check("range_dispatches", flag_cnt - f0, RC_EN ? 1 : 2);
    f0 = flag_cnt;
    push_ev(16'h1B1B);
    push_ev(16'h001C);
    wait_drain(200);
    check("range_edge_dispatches", flag_cnt - f0, RC_EN ? 1 : 2);

    // Randomized traffic
    gen_mode = 2;
    for (int i = 0; i < 300; i++) begin
      ev = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 31))};
      cycle(1'($urandom_range(0, 1)), ev, 1'b0, acc);
    end
    wait_drain(3000);
    check("random_gen_quiet", 32'(operating_flag), 0);

    // Asynchronous reset while the generator is operating
    gen_mode = 0; gen_delay = 2; gen_hold = 20;
    for (int i = 0; i < 3; i++) push_ev(rand_ev_in());
    wait_op_high(20);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    drop_exp = 0;
    #1;
    check("arst_flag", 32'(AER_input_flag), 0);
    check("arst_word", 32'(AER_conv_layer1), 0);
    check("arst_count", 32'(queue_count), 0);
    check("arst_ready", 32'(spike_in_ready), 1);
    check("arst_err", 32'(err_stuck), 0);
`ifdef CONV1_AER_RANGE_CHECK_EN
    check("arst_drop", 32'(drop_count), 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = flag_cnt;
    repeat (40) @(negedge clk);
    check("arst_no_flags", flag_cnt - f0, 0);
    push_ev(16'h0A0B);
    wait_drain(200);
    check("arst_new_dispatch", flag_cnt - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
